// File: rtl/param_register_file.sv
// param_register_file: parametrised CPU register file with memory-mapped I/O, sticky flags and synchronised input
module param_register_file #(
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 5,
    parameter int N_FLAGS         = 7,
    parameter int FLAG_ADDR       = 31,
    parameter int DOUT_ADDR       = 30,
    parameter int GOUT_ADDR       = 29,
    parameter int DINP_ADDR       = 28,
    parameter int FLAG_EDGE       = 1,
    parameter int DIN_SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flag_mask,
    input  logic [ADDR_W-1:0]         a_addr,
    output logic [DATA_W-1:0]         a_data,
    input  logic [ADDR_W-1:0]         b_addr,
    input  logic                      b_wr_en,
    input  logic [DATA_W-1:0]         b_data_in,
    output logic [DATA_W-1:0]         b_data_out,
    input  logic [N_FLAGS-1:0]        flag_in,
    input  logic [DATA_W-1:0]         din,
    output logic [DATA_W-1:0]         gout,
    output logic [DATA_W-1:0]         dout,
    output logic [DATA_W-1:0]         flag,
    output logic [N_FLAGS-1:0]        flag_overrun,
    input  logic                      atc_en,
    input  logic [$clog2(DATA_W)-1:0] atc_bit,
    output logic                      atc_out
);
    localparam logic [ADDR_W-1:0] FA = ADDR_W'(FLAG_ADDR);
    localparam logic [ADDR_W-1:0] DA = ADDR_W'(DINP_ADDR);
    localparam logic [ADDR_W-1:0] GA = ADDR_W'(GOUT_ADDR);
    localparam logic [ADDR_W-1:0] OA = ADDR_W'(DOUT_ADDR);

    logic [DATA_W-1:0]  regs [2**ADDR_W];
    logic [DATA_W-1:0]  sync [DIN_SYNC_STAGES];
    logic [N_FLAGS-1:0] flag_q, hist, ev, clr;
    logic               atc_hit;

    assign flag       = DATA_W'(flag_q);
    assign a_data     = a_addr == FA ? flag : regs[a_addr];
    assign b_data_out = b_addr == FA ? flag : regs[b_addr];
    assign gout       = regs[GA];
    assign dout       = regs[OA];
    assign atc_hit    = atc_en && (32'(atc_bit) < N_FLAGS);
    assign atc_out    = atc_hit & flag[atc_bit];
    assign ev         = (FLAG_EDGE != 0 ? flag_in & ~hist : flag_in) & {N_FLAGS{~flag_mask}};

    // one-hot clear mask for a qualified test-and-clear request
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_FLAGS; i++) clr[i] = atc_hit && enable && (32'(atc_bit) == i);
    end

    // register array: port b writes everywhere except FLAG and DINP, DINP reloads every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else begin
            if (enable && b_wr_en && b_addr != FA && b_addr != DA) regs[b_addr] <= b_data_in;
            regs[DA] <= sync[DIN_SYNC_STAGES-1];
        end
    end

    // din synchroniser chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DIN_SYNC_STAGES; i++) sync[i] <= '0;
        end else begin
            sync[0] <= din;
            for (int i = 1; i < DIN_SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
    end

    // sticky flags: events set, ATC clears, a coincident event beats the clear and leaves overrun alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q       <= '0;
            hist         <= '0;
            flag_overrun <= '0;
        end else begin
            hist         <= flag_in;
            flag_q       <= (flag_q & ~clr) | ev;
            flag_overrun <= (flag_overrun & ~(clr & ~ev)) | (ev & flag_q & ~clr);
        end
    end
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: directed-vector bench for param_register_file (edge instance plus a level-mode instance)
module tb_param_register_file;
    logic       clk = 0;
    logic       reset, enable, flag_mask, b_wr_en, atc_en;
    logic [4:0] a_addr, b_addr;
    logic [7:0] b_data_in, din;
    logic [6:0] flag_in;
    logic [2:0] atc_bit;
    logic [7:0] a_data, b_data_out, gout, dout, flag;
    logic [6:0] flag_overrun;
    logic       atc_out;
    logic [7:0] l_a_data, l_b_data_out, l_gout, l_dout, l_flag;
    logic [6:0] l_flag_overrun;
    logic       l_atc_out;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    param_register_file u_dut (
        .clk(clk), .reset(reset), .enable(enable), .flag_mask(flag_mask),
        .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr), .b_wr_en(b_wr_en),
        .b_data_in(b_data_in), .b_data_out(b_data_out), .flag_in(flag_in), .din(din),
        .gout(gout), .dout(dout), .flag(flag), .flag_overrun(flag_overrun),
        .atc_en(atc_en), .atc_bit(atc_bit), .atc_out(atc_out)
    );

    param_register_file #(.FLAG_EDGE(0)) u_lvl (
        .clk(clk), .reset(reset), .enable(enable), .flag_mask(flag_mask),
        .a_addr(a_addr), .a_data(l_a_data), .b_addr(b_addr), .b_wr_en(b_wr_en),
        .b_data_in(b_data_in), .b_data_out(l_b_data_out), .flag_in(flag_in), .din(din),
        .gout(l_gout), .dout(l_dout), .flag(l_flag), .flag_overrun(l_flag_overrun),
        .atc_en(atc_en), .atc_bit(atc_bit), .atc_out(l_atc_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; enable = 0; flag_mask = 0; b_wr_en = 0; atc_en = 0;
        a_addr = 5'd28; b_addr = 5'd29; b_data_in = 0; din = 8'hA5; flag_in = 0; atc_bit = 0;
        step(); step(); step();
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data_out, 0);
        chk("rst_gout", gout, 0);
        chk("rst_dout", dout, 0);
        chk("rst_flag", flag, 0);
        chk("rst_ovr", flag_overrun, 0);
        chk("rst_atc", atc_out, 0);
        @(negedge clk) reset = 0;
        step(); step();
        chk("dinp_2edges", a_data, 0);
        step();
        chk("dinp_3edges", a_data, 8'hA5);

        enable = 1; b_wr_en = 1; b_addr = 5'd5; b_data_in = 8'h3C; a_addr = 5'd5;
        step();
        chk("wr_a5", a_data, 8'h3C);
        b_addr = 5'd31; b_data_in = 8'hFF;
        step();
        b_addr = 5'd28; b_data_in = 8'h11;
        step();
        b_addr = 5'd29; b_data_in = 8'h5A;
        step();
        b_addr = 5'd30; b_data_in = 8'hC3;
        step();
        b_addr = 5'd6; b_data_in = 8'h77;
        #1;
        chk("no_bypass", b_data_out, 0);
        step();
        chk("wr_b6", b_data_out, 8'h77);
        b_wr_en = 0;
        chk("flag_protect", flag, 0);
        a_addr = 5'd28;
        #1;
        chk("dinp_protect", a_data, 8'hA5);
        chk("gout_wr", gout, 8'h5A);
        chk("dout_wr", dout, 8'hC3);

        flag_in = 7'h04;
        step();
        chk("edge_set", flag, 8'h04);
        repeat (4) step();
        chk("edge_hold", flag, 8'h04);
        chk("edge_no_ovr", flag_overrun, 0);
        flag_in = 0;
        step();
        flag_in = 7'h04;
        step();
        chk("ovr_set", flag_overrun, 7'h04);

        atc_en = 1; atc_bit = 3'd2;
        #1;
        chk("atc_out_hit", atc_out, 1);
        step();
        atc_en = 0;
        chk("atc_clr_flag", flag, 0);
        chk("atc_clr_ovr", flag_overrun, 0);
        flag_in = 0;
        step();
        flag_in = 7'h04;
        step();
        atc_en = 1; atc_bit = 3'd7;
        #1;
        chk("atc7_out", atc_out, 0);
        step();
        chk("atc7_flag", flag, 8'h04);
        enable = 0; atc_bit = 3'd2;
        #1;
        chk("atc_noen_out", atc_out, 1);
        step();
        chk("atc_noen_flag", flag, 8'h04);
        enable = 1; atc_bit = 3'd1; flag_in = 7'h06;
        step();
        atc_en = 0;
        chk("collide_flag", flag, 8'h06);
        chk("collide_ovr", flag_overrun, 0);

        flag_mask = 1; flag_in = 7'h07;
        step(); step();
        chk("mask_edge", flag[0], 0);
        chk("mask_lvl", l_flag[0], 0);
        flag_mask = 0;
        step();
        chk("unmask_edge", flag[0], 0);
        chk("unmask_lvl", l_flag[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
